gru_gate_mac: RTL and testbench
===============================

# gru_gate_mac

Pre-activation multiply-accumulate stage for one GRU gate. It streams N weight/input pairs, accumulates their Q4.12 products plus a bias at full precision, then rounds and saturates the sum. The result is presented in the sign-magnitude Q4.12 format that the sigmoid/tanh activation stage directly downstream consumes. A start/valid/ready handshake sits on each side.

## Interface
Parameters:
- N, 8, vector length; number of products per result; N ≥ 1
- AW, 40, accumulator width, signed; must be ≥ 32 + clog2(N) + 1

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- start  in  1  begin a new accumulation; sampled only in IDLE
- bias  in  16  two's-complement Q4.12 bias; captured on accepted start
- in_valid  in  1  w_in/x_in pair valid this cycle
- in_ready  out  1  block accepts a pair this cycle (high only in ACC)
- w_in  in  16  weight, two's-complement Q4.12
- x_in  in  16  input/hidden element, two's-complement Q4.12
- out_valid  out  1  result valid; drives the activation stage's chip-select
- out_ready  in  1  downstream accepts the result
- y_out  out  16  result, sign-magnitude Q4.12: bit 15 is the sign, bits 14:0 the magnitude
- busy  out  1  high whenever state ≠ IDLE

## Operation
- States: IDLE, ACC, ROUND, OUT.
- IDLE, start=1:
  - acc ← sign-extend(bias) << 12 (Q.24 alignment)
  - cnt ← 0
  - go to ACC
- IDLE, start=0: stay in IDLE.
- start outside IDLE is ignored.
- ACC:
  - in_ready=1.
  - Each cycle with in_valid=1: acc ← acc + sext(w_in × x_in), using a signed 16×16→32 product, Q8.24.
  - Each accepted pair increments cnt.
  - Cycles with in_valid=0 change nothing.
  - When the pair with cnt = N−1 is accepted, go to ROUND.
- ROUND (one cycle):
  - r = (acc + 2^11) >>> 12, arithmetic shift (round half toward +∞).
  - Saturate r to [−32767, +32767].
  - Convert to sign-magnitude:
    - r ≥ 0 → {0, r[14:0]}
    - r < 0 → {1, (−r)[14:0]}
  - A result of exactly 0 is always 0x0000 (never 0x8000).
  - Register into y_out; go to OUT.
- OUT:
  - out_valid=1; y_out held stable.
  - When out_ready=1 the transfer completes; go to IDLE.
- rst=1 in any state:
  - next state IDLE; acc, cnt cleared.
  - y_out=0x0000; out_valid=0, in_ready=0, busy=0.
  - Any in-flight accumulation is discarded.

## Timing
- Reset values:
  - y_out=0x0000
  - out_valid=0
  - in_ready=0
  - busy=0
- Cycle c, start accepted → in_ready=1 and busy=1 from c+1.
- Last pair accepted at cycle t:
  - in_ready=0 from t+1 (ROUND)
  - out_valid=1 and y_out valid from t+2
- Minimum start-to-result latency: N+2 cycles with in_valid held high.
- out_valid/y_out hold indefinitely until out_ready=1.
- out_ready=1 at cycle u in OUT → out_valid=0 and busy=0 at u+1. A new start may be accepted at u+1.
- out_ready is ignored outside OUT.
- in_valid is ignored outside ACC, and no pair is consumed then.
- No overflow inside acc for N ≤ 2^(AW−33); saturation is applied only at ROUND.

## Test plan
- N=4, bias=0x0000, w=0x0800 (0.5), x=0x1000 (1.0) ×4, in_valid continuous → out_valid 6 cycles after start, y_out=0x2000 (+2.0).
- N=4, bias=0x0800, w=0xF000 (−1), x=0x1800 (1.5) ×4 → r = −6.0+0.5 = −5.5 → y_out=0xD800.
- Saturation: w=x=0x7FFF ×4 → y_out=0x7FFF. Repeat with w=0x8001 → y_out=0xFFFF.
- Rounding, N=4, bias=0, first pair w=0x0001, x=0x0800, rest 0 → y_out=0x0001. Same test with w=0xFFFF → y_out=0x0000 (no negative zero).
- Handshake:
  - in_valid toggles 1,0,1,0…: result unchanged versus continuous input.
  - start pulsed mid-ACC: ignored.
  - out_ready held low 5 cycles in OUT: out_valid and y_out stable; exactly one transfer when out_ready rises.
  - Next start on the following cycle is accepted.
- rst asserted after 2 of 4 pairs → next cycle busy=0, in_ready=0, out_valid=0, y_out=0x0000. A fresh 4-pair run then gives the correct result with no residue from the aborted run.

Source files
------------

// File: rtl/gru_gate_mac.sv
// Pre-activation MAC for one GRU gate: bias + sum of N Q4.12 products at full precision,
// then round, saturate and emit the sign-magnitude Q4.12 result for the activation stage.
module gru_gate_mac #(
   parameter int N  = 8,
   parameter int AW = 40
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [15:0] bias,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [15:0] w_in,
   input  logic [15:0] x_in,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [15:0] y_out,
   output logic        busy
);

   localparam int CW = (N > 1) ? $clog2(N) : 1;
   localparam logic [CW-1:0] LAST_IDX = CW'(N - 1);
   localparam logic signed [AW-1:0] SAT_HI = AW'(32767);
   localparam logic signed [AW-1:0] SAT_LO = -(AW'(32767));

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ACC   = 2'd1,
      S_ROUND = 2'd2,
      S_OUT   = 2'd3
   } state_t;

   state_t r_state;
   state_t w_state_next;

   logic signed [AW-1:0] r_acc;
   logic [CW-1:0]        r_cnt;
   logic [15:0]          r_y;

   logic signed [31:0]   w_prod;
   logic signed [AW-1:0] w_prod_ext;
   logic signed [AW-1:0] w_bias_ext;
   logic signed [AW-1:0] w_rnd;
   logic signed [AW-1:0] w_shift;
   logic signed [15:0]   w_sat;
   logic [15:0]          w_neg;
   logic [15:0]          w_y;
   logic                 w_take;

   assign w_prod     = $signed(w_in) * $signed(x_in);
   assign w_prod_ext = {{(AW-32){w_prod[31]}}, w_prod};
   // Bias is Q4.12; shifting by 12 aligns it with the Q8.24 products.
   assign w_bias_ext = {{(AW-28){bias[15]}}, bias, 12'h000};
   assign w_take     = (r_state == S_ACC) && in_valid;

   // Add half an LSB then arithmetic shift: round half toward +inf.
   assign w_rnd   = r_acc + {{(AW-12){1'b0}}, 12'h800};
   assign w_shift = w_rnd >>> 12;

   always_comb begin
      if (w_shift > SAT_HI) begin
         w_sat = 16'sh7FFF;
      end else if (w_shift < SAT_LO) begin
         w_sat = 16'sh8001;
      end else begin
         w_sat = w_shift[15:0];
      end
   end

   // Symmetric saturation keeps -r representable; a negative r is never zero.
   assign w_neg = -w_sat;
   assign w_y   = w_sat[15] ? {1'b1, w_neg[14:0]} : {1'b0, w_sat[14:0]};

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      in_ready     = 1'b0;
      out_valid    = 1'b0;
      busy         = 1'b1;
      case (r_state)
         S_IDLE: begin
            busy = 1'b0;
            if (start) begin
               w_state_next = S_ACC;
            end
         end
         S_ACC: begin
            in_ready = 1'b1;
            if (in_valid && (r_cnt == LAST_IDX)) begin
               w_state_next = S_ROUND;
            end
         end
         S_ROUND: begin
            w_state_next = S_OUT;
         end
         S_OUT: begin
            out_valid = 1'b1;
            if (out_ready) begin
               w_state_next = S_IDLE;
            end
         end
         default: begin
            w_state_next = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_acc <= '0;
         r_cnt <= '0;
         r_y   <= 16'h0000;
      end else begin
         if ((r_state == S_IDLE) && start) begin
            r_acc <= w_bias_ext;
            r_cnt <= '0;
         end else if (w_take) begin
            r_acc <= r_acc + w_prod_ext;
            r_cnt <= r_cnt + CW'(1);
         end
         if (r_state == S_ROUND) begin
            r_y <= w_y;
         end
      end
   end

   assign y_out = r_y;

endmodule

// File: tb/tb_gru_gate_mac.sv
// Directed bench for gru_gate_mac (N=4): hand-computed vectors covering rounding,
// saturation, negative-zero suppression, handshake stalls and mid-run reset.
module tb_gru_gate_mac;

   localparam int N = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [15:0] bias;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] w_in;
   logic [15:0] x_in;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] y_out;
   logic        busy;

   int n_checks = 0;
   int n_pass   = 0;

   always #5 clk = ~clk;

   gru_gate_mac #(.N(N), .AW(40)) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .bias      (bias),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .w_in      (w_in),
      .x_in      (x_in),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .y_out     (y_out),
      .busy      (busy)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got %h, expected %h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // One full transaction: start, N pairs, optional stalls, result check, transfer.
   task automatic run(input string name, input logic [15:0] b,
                      input logic [63:0] wv, input logic [63:0] xv,
                      input bit toggle, input bit midstart, input int hold,
                      input logic [15:0] exp_y);
      int k;
      int cyc;
      logic [15:0] y_seen;
      start = 1'b1;
      bias  = b;
      step();
      start = 1'b0;
      check({name, " busy_after_start"}, 32'(busy), 32'd1);
      check({name, " in_ready_after_start"}, 32'(in_ready), 32'd1);
      k   = 0;
      cyc = 0;
      while (k < N) begin
         in_valid = toggle ? ((cyc % 2) == 0) : 1'b1;
         // Idle cycles carry junk data so any wrongly consumed pair shows up.
         w_in  = in_valid ? wv[16*k +: 16] : 16'h7FFF;
         x_in  = in_valid ? xv[16*k +: 16] : 16'h7FFF;
         start = midstart && (cyc == 1);
         step();
         if (in_valid) k++;
         cyc++;
      end
      in_valid = 1'b0;
      start    = 1'b0;
      w_in     = 16'h0000;
      x_in     = 16'h0000;
      check({name, " in_ready_round"}, 32'(in_ready), 32'd0);
      check({name, " out_valid_round"}, 32'(out_valid), 32'd0);
      step();
      check({name, " out_valid"}, 32'(out_valid), 32'd1);
      check({name, " y_out"}, 32'(y_out), 32'(exp_y));
      y_seen = y_out;
      for (int i = 0; i < hold; i++) begin
         step();
         check({name, " hold_out_valid"}, 32'(out_valid), 32'd1);
         check({name, " hold_y_out"}, 32'(y_out), 32'(exp_y));
      end
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      check({name, " out_valid_after_xfer"}, 32'(out_valid), 32'd0);
      check({name, " busy_after_xfer"}, 32'(busy), 32'd0);
      $display("%s: y_out=%h expected=%h", name, y_seen, exp_y);
   endtask

   initial begin
      rst       = 1'b1;
      start     = 1'b0;
      bias      = 16'h0000;
      in_valid  = 1'b0;
      w_in      = 16'h0000;
      x_in      = 16'h0000;
      out_ready = 1'b0;
      step();
      step();
      check("reset y_out", 32'(y_out), 32'h0000);
      check("reset out_valid", 32'(out_valid), 32'd0);
      check("reset in_ready", 32'(in_ready), 32'd0);
      check("reset busy", 32'(busy), 32'd0);
      rst = 1'b0;
      step();

      run("plus_two",    16'h0000, {4{16'h0800}}, {4{16'h1000}}, 1'b0, 1'b0, 0, 16'h2000);
      run("minus_5p5",   16'h0800, {4{16'hF000}}, {4{16'h1800}}, 1'b0, 1'b0, 0, 16'hD800);
      run("sat_pos",     16'h0000, {4{16'h7FFF}}, {4{16'h7FFF}}, 1'b0, 1'b0, 0, 16'h7FFF);
      run("sat_neg",     16'h0000, {4{16'h8001}}, {4{16'h7FFF}}, 1'b0, 1'b0, 0, 16'hFFFF);
      run("round_up",    16'h0000, 64'h0000_0000_0000_0001, 64'h0000_0000_0000_0800,
          1'b0, 1'b0, 0, 16'h0001);
      run("no_neg_zero", 16'h0000, 64'h0000_0000_0000_FFFF, 64'h0000_0000_0000_0800,
          1'b0, 1'b0, 0, 16'h0000);
      run("round_below", 16'h0000, 64'h0000_0000_0000_0001, 64'h0000_0000_0000_07FF,
          1'b0, 1'b0, 0, 16'h0000);
      run("minus_lsb",   16'h0000, 64'h0000_0000_0000_FFFF, 64'h0000_0000_0000_0801,
          1'b0, 1'b0, 0, 16'h8001);
      run("toggle_in",   16'h0800, {4{16'hF000}}, {4{16'h1800}}, 1'b1, 1'b0, 0, 16'hD800);
      run("mid_start",   16'h0000, {4{16'h0800}}, {4{16'h1000}}, 1'b0, 1'b1, 5, 16'h2000);

      // Abort a run after two pairs, then confirm a clean restart.
      start = 1'b1;
      bias  = 16'h0800;
      step();
      start    = 1'b0;
      in_valid = 1'b1;
      w_in     = 16'h7FFF;
      x_in     = 16'h7FFF;
      step();
      step();
      in_valid = 1'b0;
      rst      = 1'b1;
      step();
      rst = 1'b0;
      check("abort busy", 32'(busy), 32'd0);
      check("abort in_ready", 32'(in_ready), 32'd0);
      check("abort out_valid", 32'(out_valid), 32'd0);
      check("abort y_out", 32'(y_out), 32'h0000);
      $display("abort: reset after 2 of %0d pairs", N);
      run("after_abort", 16'h0800, {4{16'hF000}}, {4{16'h1800}}, 1'b0, 1'b0, 0, 16'hD800);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
